// File: rtl/sccb_arbiter.sv
// sccb_arbiter
//   Shares one SCCB write master between NUM_REQ requesters. The arbiter picks a
//   winner (round-robin by default), latches its {reg_addr, data}, pulses
//   sccb_start, then waits for sccb_done. On a NACK it retries up to MAX_RETRY
//   extra times, and a hung master is caught by a timeout. After every
//   transaction there is an idle gap of GAP_CYCLES cycles before the next grant.
//
//   Build option: define SCCB_ARB_FIXED_PRIO_EN to make the lowest-index request
//   always win. The round-robin pointer is then held at 0.
//
// Ports
//   clk            tick clock, shared with the SCCB master
//   reset          asynchronous reset, active low
//   req            per-requester request level
//   req_addr       register address, slice i = [8i+7:8i]
//   req_data       write data, slice i = [8i+7:8i]
//   grant          one-hot owner, high from ISSUE until the response pulse
//   rsp_done       one-cycle pulse to the owner: write finished OK
//   rsp_err        one-cycle pulse to the owner: retries exhausted or timeout
//   sccb_start     one-cycle start pulse to the SCCB master
//   sccb_reg_addr  latched register address
//   sccb_data      latched write data
//   sccb_done      master completion pulse
//   sccb_nack      master saw a NACK, valid together with sccb_done
//   busy           high in every state except IDLE
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | sample req, pick winner
// ISSUE     | grant winner, latch its payload, clear retry count
// START     | one-cycle sccb_start, load timeout timer
// WAIT_DONE | wait for sccb_done, retry on NACK, give up on timeout
// GAP       | grant dropped, idle gap timer running
module sccb_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 100,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MAX_RETRY      = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   rsp_done,
   output logic [NUM_REQ-1:0]   rsp_err,
   output logic                 sccb_start,
   output logic [7:0]           sccb_reg_addr,
   output logic [7:0]           sccb_data,
   input  logic                 sccb_done,
   input  logic                 sccb_nack,
   output logic                 busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   // Timers count down and expire on zero, so they are loaded with length-1.
   localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
`ifndef SCCB_ARB_FIXED_PRIO_EN
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_START,
      ST_WAIT_DONE,
      ST_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  win_q, win_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [RTY_W-1:0]  retry_cnt_q, retry_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [7:0]        addr_q, addr_d;
   logic [7:0]        data_q, data_d;

   logic [IDX_W-1:0]   pick;
   logic [NUM_REQ-1:0] win_oh;
   logic [7:0]         addr_sel;
   logic [7:0]         data_sel;
   logic               go_gap;

   // First set request at or above rr_ptr, wrapping. Offsets are scanned from
   // the top down so the smallest offset is the last (winning) assignment.
   // With rr_ptr held at 0 this reduces to lowest-index priority.
   always_comb begin
      pick = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (rr_ptr_q == IDX_W'(j) && req[(i + j) % NUM_REQ]) begin
               pick = IDX_W'((i + j) % NUM_REQ);
            end
         end
      end
   end

   always_comb begin
      win_oh   = '0;
      addr_sel = '0;
      data_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_q == IDX_W'(i)) begin
            win_oh[i] = 1'b1;
            addr_sel  = req_addr[i*8 +: 8];
            data_sel  = req_data[i*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      rr_ptr_d    = rr_ptr_q;
      retry_cnt_d = retry_cnt_q;
      to_cnt_d    = to_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      grant       = '0;
      rsp_done    = '0;
      rsp_err     = '0;
      sccb_start  = 1'b0;
      busy        = 1'b1;
      go_gap      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (|req) begin
               win_d   = pick;
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            grant       = win_oh;
            addr_d      = addr_sel;
            data_d      = data_sel;
            retry_cnt_d = '0;
            state_d     = ST_START;
         end

         ST_START: begin
            grant      = win_oh;
            sccb_start = 1'b1;
            to_cnt_d   = TO_LOAD;
            state_d    = ST_WAIT_DONE;
         end

         ST_WAIT_DONE: begin
            grant = win_oh;
            if (to_cnt_q != '0) begin
               to_cnt_d = to_cnt_q - 1'b1;
            end
            // A completion in the timeout cycle is honoured over the timeout.
            if (sccb_done) begin
               if (!sccb_nack) begin
                  rsp_done = win_oh;
                  go_gap   = 1'b1;
               end else if (retry_cnt_q < RTY_MAX) begin
                  retry_cnt_d = retry_cnt_q + 1'b1;
                  state_d     = ST_START;
               end else begin
                  rsp_err = win_oh;
                  go_gap  = 1'b1;
               end
            end else if (to_cnt_q == '0) begin
               rsp_err = win_oh;
               go_gap  = 1'b1;
            end
         end

         ST_GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (go_gap) begin
         state_d   = ST_GAP;
         gap_cnt_d = GAP_LOAD;
`ifdef SCCB_ARB_FIXED_PRIO_EN
         rr_ptr_d  = '0;
`else
         rr_ptr_d  = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         win_q       <= '0;
         rr_ptr_q    <= '0;
         retry_cnt_q <= '0;
         to_cnt_q    <= '0;
         gap_cnt_q   <= '0;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         rr_ptr_q    <= rr_ptr_d;
         retry_cnt_q <= retry_cnt_d;
         to_cnt_q    <= to_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
      end
   end

   assign sccb_reg_addr = addr_q;
   assign sccb_data     = data_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
module tb_sccb_arbiter;

   localparam int N   = 4;
   localparam int GAP = 100;
   localparam int TO  = 1024;
   localparam int MR  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N*8-1:0] req_addr;
   logic [N*8-1:0] req_data;
   logic [N-1:0]  grant;
   logic [N-1:0]  rsp_done;
   logic [N-1:0]  rsp_err;
   logic          sccb_start;
   logic [7:0]    sccb_reg_addr;
   logic [7:0]    sccb_data;
   logic          sccb_done;
   logic          sccb_nack;
   logic          busy;

   logic [7:0] addr_tab [N];
   logic [7:0] data_tab [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sccb_arbiter #(
      .NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
      .grant(grant), .rsp_done(rsp_done), .rsp_err(rsp_err), .sccb_start(sccb_start),
      .sccb_reg_addr(sccb_reg_addr), .sccb_data(sccb_data), .sccb_done(sccb_done),
      .sccb_nack(sccb_nack), .busy(busy)
   );

   // Looks at the current negedge first, then advances; no checking here.
   task automatic wait_start(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (sccb_start === 1'b1) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset;
      req = 4'b1111;
      @(negedge clk);
      #1;
      checks++;
      if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
      checks++;
      if ({rsp_done, rsp_err} !== 8'h00) begin errors++; $display("FAIL reset_rsp: got %h expected 00", {rsp_done, rsp_err}); end
      checks++;
      if ({sccb_start, busy} !== 2'b00) begin errors++; $display("FAIL reset_start_busy: got %b expected 00", {sccb_start, busy}); end
      checks++;
      if ({sccb_reg_addr, sccb_data} !== 16'h0000) begin errors++; $display("FAIL reset_payload: got %h expected 0000", {sccb_reg_addr, sccb_data}); end
      req = 4'b0000;
   endtask

   task automatic test_single;
      bit ok;
      int nstart;
      req = 4'b0001;
      wait_start(10, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_start: got 0 expected 1"); end
      checks++;
      if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", grant); end
      checks++;
      if (sccb_reg_addr !== 8'h12 || sccb_data !== 8'h80) begin
         errors++; $display("FAIL single_payload: got %h/%h expected 12/80", sccb_reg_addr, sccb_data);
      end
      nstart = 0;
      repeat (39) begin
         @(negedge clk);
         if (sccb_start) nstart++;
      end
      @(negedge clk);
      if (sccb_start) nstart++;
      sccb_done = 1'b1;
      sccb_nack = 1'b0;
      #1;
      checks++;
      if (nstart != 0) begin errors++; $display("FAIL single_extra_start: got %0d expected 0", nstart); end
      checks++;
      if (rsp_done !== 4'b0001 || rsp_err !== 4'b0000) begin
         errors++; $display("FAIL single_rsp: got done=%b err=%b expected 0001/0000", rsp_done, rsp_err);
      end
      checks++;
      if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant_at_rsp: got %b expected 0001", grant); end
      @(negedge clk);
      sccb_done = 1'b0;
      req = 4'b0000;
      #1;
      checks++;
      if (rsp_done !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b1) begin
         errors++; $display("FAIL single_gap_entry: got done=%b grant=%b busy=%b expected 0000/0000/1", rsp_done, grant, busy);
      end
      repeat (GAP - 1) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_end_busy: got %b expected 1", busy); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_after_gap: got %b expected 0", busy); end
   endtask

   task automatic test_round_robin;
      bit ok;
      int exp_w [6];
      logic [3:0] exp_oh;
`ifdef SCCB_ARB_FIXED_PRIO_EN
      exp_w = '{0, 0, 0, 0, 0, 0};
`else
      exp_w = '{0, 1, 3, 0, 1, 3};
`endif
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      req = 4'b1011;
      for (int t = 0; t < 6; t++) begin
         exp_oh = 4'b0001 << exp_w[t];
         wait_start(250, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL rr_start_%0d: got 0 expected 1", t); end
         checks++;
         if (grant !== exp_oh) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", t, grant, exp_oh); end
         checks++;
         if (sccb_reg_addr !== addr_tab[exp_w[t]]) begin
            errors++; $display("FAIL rr_addr_%0d: got %h expected %h", t, sccb_reg_addr, addr_tab[exp_w[t]]);
         end
         @(negedge clk);
         sccb_done = 1'b1;
         sccb_nack = 1'b0;
         #1;
         checks++;
         if (rsp_done !== exp_oh) begin errors++; $display("FAIL rr_rsp_%0d: got %b expected %b", t, rsp_done, exp_oh); end
         @(negedge clk);
         sccb_done = 1'b0;
      end
      req = 4'b0000;
      wait_idle(300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_idle: got 0 expected 1"); end
   endtask

   task automatic test_nack_retry;
      bit ok;
      int nstart;
      for (int pass = 0; pass < 2; pass++) begin
         req = 4'b0100;
         for (int k = 0; k <= MR; k++) begin
            wait_start(250, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL nack_start_p%0d_a%0d: got 0 expected 1", pass, k); end
            checks++;
            if (grant !== 4'b0100 || sccb_reg_addr !== 8'h34 || sccb_data !== 8'h56) begin
               errors++; $display("FAIL nack_payload_p%0d_a%0d: got %b %h/%h expected 0100 34/56", pass, k, grant, sccb_reg_addr, sccb_data);
            end
            @(negedge clk);
            sccb_done = 1'b1;
            sccb_nack = (pass == 1) || (k < MR);
            #1;
            checks++;
            if (k < MR) begin
               if ({rsp_done, rsp_err} !== 8'h00) begin
                  errors++; $display("FAIL nack_early_rsp_p%0d_a%0d: got %h expected 00", pass, k, {rsp_done, rsp_err});
               end
            end else if (pass == 0) begin
               if (rsp_done !== 4'b0100 || rsp_err !== 4'b0000) begin
                  errors++; $display("FAIL nack_final_ok: got done=%b err=%b expected 0100/0000", rsp_done, rsp_err);
               end
            end else begin
               if (rsp_err !== 4'b0100 || rsp_done !== 4'b0000) begin
                  errors++; $display("FAIL nack_exhausted: got done=%b err=%b expected 0000/0100", rsp_done, rsp_err);
               end
            end
            @(negedge clk);
            sccb_done = 1'b0;
            sccb_nack = 1'b0;
         end
         req = 4'b0000;
         nstart = 0;
         repeat (150) begin
            if (sccb_start) nstart++;
            @(negedge clk);
         end
         checks++;
         if (nstart != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL nack_no_more_starts_p%0d: got starts=%0d busy=%b expected 0/0", pass, nstart, busy);
         end
      end
   endtask

   task automatic test_timeout;
      bit ok;
      int first;
      logic [3:0] err_seen;
      req = 4'b1000;
      wait_start(10, ok);
      checks++;
      if (!ok || grant !== 4'b1000) begin errors++; $display("FAIL to_start: got ok=%0d grant=%b expected 1/1000", ok, grant); end
      req = 4'b1001;
      first = 0;
      err_seen = 4'b0000;
      for (int k = 1; k <= TO; k++) begin
         @(negedge clk);
         if (first == 0 && rsp_err !== 4'b0000) begin
            first = k;
            err_seen = rsp_err;
         end
      end
      checks++;
      if (first != TO) begin errors++; $display("FAIL to_latency: got %0d expected %0d", first, TO); end
      checks++;
      if (err_seen !== 4'b1000) begin errors++; $display("FAIL to_err_owner: got %b expected 1000", err_seen); end
      @(negedge clk);
      req = 4'b0001;
      wait_start(250, ok);
      checks++;
      if (!ok || grant !== 4'b0001) begin errors++; $display("FAIL to_next_served: got ok=%0d grant=%b expected 1/0001", ok, grant); end
      @(negedge clk);
      sccb_done = 1'b1;
      #1;
      checks++;
      if (rsp_done !== 4'b0001) begin errors++; $display("FAIL to_next_rsp: got %b expected 0001", rsp_done); end
      @(negedge clk);
      sccb_done = 1'b0;
      req = 4'b0000;
      wait_idle(300, ok);
   endtask

   task automatic test_gap_drop;
      bit ok;
      bit saw_g1;
      req = 4'b0001;
      wait_start(10, ok);
      checks++;
      if (!ok || grant !== 4'b0001) begin errors++; $display("FAIL drop_first: got ok=%0d grant=%b expected 1/0001", ok, grant); end
      req = 4'b0011;
      @(negedge clk);
      sccb_done = 1'b1;
      @(negedge clk);
      sccb_done = 1'b0;
      req = 4'b0010;
      saw_g1 = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (grant[1]) saw_g1 = 1'b1;
      end
      req = 4'b1000;
      ok = 1'b0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (grant[1]) saw_g1 = 1'b1;
         if (sccb_start) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || grant !== 4'b1000) begin errors++; $display("FAIL drop_next_grant: got ok=%0d grant=%b expected 1/1000", ok, grant); end
      @(negedge clk);
      sccb_done = 1'b1;
      @(negedge clk);
      sccb_done = 1'b0;
      req = 4'b0000;
      repeat (150) begin
         @(negedge clk);
         if (grant[1]) saw_g1 = 1'b1;
      end
      checks++;
      if (saw_g1) begin errors++; $display("FAIL drop_no_grant1: got 1 expected 0"); end
   endtask

   task automatic test_done_at_timeout;
      bit ok;
      bit early_err;
      req = 4'b0001;
      wait_start(250, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL coinc_start: got 0 expected 1"); end
      early_err = 1'b0;
      repeat (TO - 1) begin
         @(negedge clk);
         if (rsp_err !== 4'b0000) early_err = 1'b1;
      end
      @(negedge clk);
      sccb_done = 1'b1;
      sccb_nack = 1'b0;
      #1;
      checks++;
      if (early_err || rsp_done !== 4'b0001 || rsp_err !== 4'b0000) begin
         errors++; $display("FAIL coinc_done_wins: got early=%0d done=%b err=%b expected 0/0001/0000", early_err, rsp_done, rsp_err);
      end
      @(negedge clk);
      sccb_done = 1'b0;
      req = 4'b0000;
      wait_idle(300, ok);
   endtask

   task automatic test_reset_mid;
      bit ok;
      int nstart;
      req = 4'b0010;
      wait_start(250, ok);
      repeat (5) @(negedge clk);
      checks++;
      if (!ok || grant !== 4'b0010 || busy !== 1'b1) begin
         errors++; $display("FAIL rmid_in_wait: got ok=%0d grant=%b busy=%b expected 1/0010/1", ok, grant, busy);
      end
      reset = 1'b0;
      sccb_done = 1'b1;
      #1;
      checks++;
      if ({grant, rsp_done, rsp_err, sccb_start, busy} !== 14'h0) begin
         errors++; $display("FAIL rmid_outputs: got grant=%b done=%b err=%b start=%b busy=%b expected all 0", grant, rsp_done, rsp_err, sccb_start, busy);
      end
      checks++;
      if ({sccb_reg_addr, sccb_data} !== 16'h0000) begin
         errors++; $display("FAIL rmid_payload: got %h expected 0000", {sccb_reg_addr, sccb_data});
      end
      @(negedge clk);
      sccb_done = 1'b0;
      req = 4'b0000;
      reset = 1'b1;
      nstart = 0;
      repeat (20) begin
         @(negedge clk);
         if (sccb_start || rsp_done != 0 || rsp_err != 0) nstart++;
      end
      checks++;
      if (nstart != 0) begin errors++; $display("FAIL rmid_quiet_after: got %0d expected 0", nstart); end
   endtask

   initial begin
      addr_tab = '{8'h12, 8'h21, 8'h34, 8'h43};
      data_tab = '{8'h80, 8'h91, 8'h56, 8'hA7};
      for (int i = 0; i < N; i++) begin
         req_addr[i*8 +: 8] = addr_tab[i];
         req_data[i*8 +: 8] = data_tab[i];
      end
      reset = 1'b0;
      req = '0;
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      reset = 1'b1;
      @(negedge clk);
      test_single;
      test_round_robin;
      test_nack_retry;
      test_timeout;
      test_gap_drop;
      test_done_at_timeout;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sccb_arbiter.md
Name: sccb_arbiter

Overview:
- Round-robin arbiter and transaction scheduler that shares one SCCB write master between NUM_REQ requesters.
- Typical requesters: the OV7670 config-ROM sequencer, runtime exposure/gain tuning, and debug UART writes.
- Latches the winning requester's {reg_addr, data}, issues a single-cycle start to the SCCB master, waits for done, retries on NACK, guards against a hung master with a timeout, and enforces an idle gap between transactions.
- Clocked by the same tick clock as the SCCB master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 100, idle cycles after each transaction before the next grant.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for sccb_done after start.
- MAX_RETRY, 2, extra attempts after a NACK before an error is reported.

Ports:
- clk  in  1  tick-domain clock, shared with the SCCB master.
- reset  in  1  asynchronous reset, active-low: asserted while reset = 0.
- req  in  NUM_REQ  per-requester request level.
- req_addr  in  NUM_REQ*8  register address; slice i = [8i+7:8i].
- req_data  in  NUM_REQ*8  write data; slice i = [8i+7:8i].
- grant  out  NUM_REQ  one-hot; high from ISSUE until the response pulse.
- rsp_done  out  NUM_REQ  one-cycle pulse to the owner: transaction finished OK.
- rsp_err  out  NUM_REQ  one-cycle pulse to the owner: NACK retries exhausted, or timeout.
- sccb_start  out  1  one-cycle start pulse to the SCCB master.
- sccb_reg_addr  out  8  latched register address.
- sccb_data  out  8  latched write data.
- sccb_done  in  1  master completion pulse.
- sccb_nack  in  1  master saw NACK; valid in the sccb_done cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - grant, rsp_done, rsp_err, sccb_start, busy = 0; sccb_reg_addr = sccb_data = 0x00.
  - rr_ptr = 0; all counters = 0.
  - Reset mid-transaction aborts silently: no rsp pulse is generated, and the master is expected to share the same reset.
- Handshake:
  - A requester raises req[i] with payload stable and holds both until it sees rsp_done[i] or rsp_err[i].
  - Dropping req[i] before it is granted withdraws the request without side effects.
  - The payload is latched in ISSUE; req[i] changes after that are ignored until the response.
- States:
  - IDLE: if any req bit is set, pick winner w = first set bit searching from rr_ptr upward with wrap-around, then go to ISSUE. Decision latency is 1 cycle.
  - ISSUE: grant = onehot(w); latch sccb_reg_addr/sccb_data from slice w; retry_cnt = 0. Next cycle go to START.
  - START: sccb_start = 1 for exactly this cycle; to_cnt = 0; go to WAIT_DONE.
  - WAIT_DONE: to_cnt increments every cycle.
    - sccb_done & !sccb_nack: rsp_done[w] = 1 for 1 cycle, go to GAP.
    - sccb_done & sccb_nack & retry_cnt < MAX_RETRY: retry_cnt++, go to START with the same payload.
    - sccb_done & sccb_nack & retry_cnt == MAX_RETRY: rsp_err[w] = 1, go to GAP.
    - to_cnt == TIMEOUT_CYCLES-1 with no sccb_done: rsp_err[w] = 1, go to GAP.
    - If sccb_done arrives in the same cycle as the timeout, sccb_done wins.
  - GAP: grant = 0; rr_ptr = (w+1) mod NUM_REQ; count GAP_CYCLES cycles, then go to IDLE. Requests are sampled only in IDLE.
- Widths and pulses:
  - Counter widths are $clog2 of (parameter+1).
  - rsp pulses are exactly one cycle wide and occur while grant[w] is still high.
- Total transactions per attempt = 1 + retries; sccb_start never asserts outside START.

Optional Feature:
- SCCB_ARB_FIXED_PRIO_EN defined: the winner is the lowest-index set req bit; rr_ptr is unused and held at 0. Use this so the config-ROM sequencer on req[0] always preempts runtime tweaks at the next IDLE.
- Not defined: round-robin as specified above.

Test Plan:
- Single request: req = 4'b0001, addr 0x12, data 0x80; sccb_done with nack = 0 after 40 cycles -> exactly one sccb_start, sccb_reg_addr = 0x12, sccb_data = 0x80, rsp_done[0] pulses once, busy low after GAP_CYCLES.
- Round-robin: req = 4'b1011 held with continuous OK completions -> grant order 0, 1, 3, 0, 1, 3; with SCCB_ARB_FIXED_PRIO_EN defined, grant order is 0, 0, 0.
- NACK retry: requester 2, master returns nack, nack, ok -> 3 sccb_start pulses with the same payload, then rsp_done[2]. With nack on all three attempts -> rsp_err[2], no rsp_done.
- Timeout: sccb_done never asserts -> rsp_err[w] exactly TIMEOUT_CYCLES cycles after sccb_start, then GAP, then the next request is served.
- Boundaries:
  - req[1] dropped while in GAP before its grant -> no grant[1].
  - sccb_done coincident with the timeout cycle -> rsp_done, not rsp_err.
  - reset driven low in WAIT_DONE -> all outputs 0 immediately, with no rsp pulse.
